// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial arithmetic family.
// Provides the serial FSM state type plus helpers that derive the digit
// count and the digit-counter width from WIDTH/DIGIT.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digits (RUN cycles) needed to cover a WIDTH-bit operand.
  function automatic int unsigned num_digits(input int unsigned width,
                                             input int unsigned digit);
    return width / digit;
  endfunction

  // Digit counter width: $clog2(n), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin.
// Ports:
//   a    minuend bit
//   b    subtrahend bit
//   bin  borrow in
//   d    difference bit
//   bout borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), with unsigned
// borrow-out and two's-complement overflow flags. DIGIT bits are processed
// per cycle, LSB first, through a ripple chain of full_subtractor cells.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, bin            minuend, subtrahend, borrow-in
//   out_valid/out_ready  result handshake
//   diff, bout, ovf      result, borrow out of MSB, signed overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned N  = num_digits(WIDTH, DIGIT);
  localparam int unsigned CW = cnt_width(N);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             bout_q;
  logic             ovf_q;
  logic             valid_q;

  logic [DIGIT-1:0]       chain_d;
  logic [DIGIT:0]         chain_b;
  logic [WIDTH+DIGIT-1:0] d_cat;
  logic                   last_digit;

  assign chain_b[0] = brw;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    full_subtractor u_fs (
      .a    (a_sr[i]),
      .b    (b_sr[i]),
      .bin  (chain_b[i]),
      .d    (chain_d[i]),
      .bout (chain_b[i+1])
    );
  end

  // New digit enters at the top; the concatenation keeps the shift legal
  // even when DIGIT == WIDTH.
  assign d_cat      = {chain_d, d_sr};
  assign last_digit = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      brw     <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      d_sr    <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> DIGIT;
          b_sr <= b_sr >> DIGIT;
          d_sr <= d_cat[WIDTH+DIGIT-1:DIGIT];
          brw  <= chain_b[DIGIT];
          cnt  <= cnt + CW'(1);
          if (last_digit) begin
            // Top cell of the final digit is the MSB: its borrow-in vs
            // borrow-out disagreement is the signed overflow.
            bout_q  <= chain_b[DIGIT];
            ovf_q   <= chain_b[DIGIT] ^ chain_b[DIGIT-1];
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = valid_q;
  assign diff      = d_sr;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule
